// File: rtl/lock_pkg.sv
// Shared types and constants for the combination-lock code sender.
package lock_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int DIGIT_W    = 4;
  localparam int CODE_W     = NUM_DIGITS * DIGIT_W;
  localparam int TIMER_W    = 16;

  // Digit 0 sits in the LSBs, so this is presses 1,2,3,4 on buttons 0..3.
  localparam logic [CODE_W-1:0] LOCK_CODE = {4'd4, 4'd3, 4'd2, 4'd1};

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_SELECT,
    ST_PRESS,
    ST_GAP,
    ST_CHECK,
    ST_DONE
  } state_t;

  function automatic logic [DIGIT_W-1:0] code_digit(input logic [CODE_W-1:0] code,
                                                    input logic [1:0] idx);
    return code[idx*DIGIT_W +: DIGIT_W];
  endfunction

endpackage

// File: rtl/lock_press_timer.sv
// Loadable down-counter that times both the CLEAR hold and the post-press gap.
module lock_press_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_value,
  output logic         zero
);

  logic [W-1:0] count_reg;

  // Saturates at zero so an idle timer keeps reporting expiry.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_value;
    end else if (count_reg != '0) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign zero = (count_reg == '0);

endmodule

// File: rtl/lock_code_sender.sv
// Drives the lock's reset/numbers/try inputs to enter a 4-digit code, then reports lock_open.
import lock_pkg::*;

module lock_code_sender #(
  parameter int GAP_CYCLES   = 1,
  parameter int RESET_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [CODE_W-1:0]     code,
  input  logic                  lock_open,
  output logic                  lock_reset,
  output logic [NUM_DIGITS-1:0] numbers,
  output logic                  try,
  output logic                  busy,
  output logic                  done,
  output logic                  ok
);

  localparam logic [1:0]         LAST_DIGIT = 2'(NUM_DIGITS - 1);
  localparam logic [TIMER_W-1:0] GAP_LOAD   = TIMER_W'(GAP_CYCLES - 1);
  localparam logic [TIMER_W-1:0] CLEAR_LOAD = TIMER_W'(RESET_CYCLES - 1);

  state_t              state_reg, state_next;
  logic [1:0]          digit_reg, digit_next;
  logic [DIGIT_W-1:0]  press_reg, press_next;
  logic [CODE_W-1:0]   code_reg, code_next;
  logic                ok_reg, ok_next;
  logic                timer_load;
  logic [TIMER_W-1:0]  timer_value;
  logic                timer_zero;
  logic [DIGIT_W-1:0]  cur_digit;

  logic                  lock_reset_reg, try_reg, busy_reg, done_reg;
  logic [NUM_DIGITS-1:0] numbers_reg;

  lock_press_timer #(.W(TIMER_W)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (timer_load),
    .load_value (timer_value),
    .zero       (timer_zero)
  );

  assign cur_digit = code_digit(code_reg, digit_reg);

  always_comb begin
    state_next  = state_reg;
    digit_next  = digit_reg;
    press_next  = press_reg;
    code_next   = code_reg;
    ok_next     = ok_reg;
    timer_load  = 1'b0;
    timer_value = '0;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          code_next   = code;
          digit_next  = '0;
          ok_next     = 1'b0;
          timer_load  = 1'b1;
          timer_value = CLEAR_LOAD;
          state_next  = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        if (timer_zero) state_next = ST_SELECT;
      end
      ST_SELECT: begin
        press_next = cur_digit;
        if (cur_digit != '0) begin
          state_next = ST_PRESS;
        end else if (digit_reg == LAST_DIGIT) begin
          state_next = ST_CHECK;
        end else begin
          digit_next = digit_reg + 2'd1;
        end
      end
      ST_PRESS: begin
        press_next  = press_reg - 1'b1;
        timer_load  = 1'b1;
        timer_value = GAP_LOAD;
        state_next  = ST_GAP;
      end
      ST_GAP: begin
        if (timer_zero) begin
          if (press_reg != '0) begin
            state_next = ST_PRESS;
          end else if (digit_reg == LAST_DIGIT) begin
            state_next = ST_CHECK;
          end else begin
            digit_next = digit_reg + 2'd1;
            state_next = ST_SELECT;
          end
        end
      end
      ST_CHECK: begin
        ok_next    = lock_open;
        state_next = ST_DONE;
      end
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= ST_IDLE;
      digit_reg      <= '0;
      press_reg      <= '0;
      code_reg       <= '0;
      ok_reg         <= 1'b0;
      lock_reset_reg <= 1'b0;
      numbers_reg    <= '0;
      try_reg        <= 1'b0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      digit_reg      <= digit_next;
      press_reg      <= press_next;
      code_reg       <= code_next;
      ok_reg         <= ok_next;
      lock_reset_reg <= (state_next == ST_CLEAR);
      numbers_reg    <= (state_next == ST_PRESS || state_next == ST_GAP)
                        ? (NUM_DIGITS'(1) << digit_next) : '0;
      try_reg        <= (state_next == ST_PRESS);
      busy_reg       <= (state_next != ST_IDLE);
      done_reg       <= (state_next == ST_DONE);
    end
  end

  assign lock_reset = lock_reset_reg;
  assign numbers    = numbers_reg;
  assign try        = try_reg;
  assign busy       = busy_reg;
  assign done       = done_reg;
  assign ok         = ok_reg;

endmodule

// File: tb/tb_lock_code_sender.sv
// Self-checking bench: three sender instances with different timing, each driving a behavioural lock.
import lock_pkg::*;

module tb_lock_code_sender;

  localparam int NU = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_s[NU];
  logic        start_s[NU];
  logic [15:0] code_s[NU];
  logic        lock_open_s[NU];
  logic        lock_reset_s[NU];
  logic [3:0]  numbers_s[NU];
  logic        try_s[NU];
  logic        busy_s[NU];
  logic        done_s[NU];
  logic        ok_s[NU];

  int vectors = 0;
  int miscompares = 0;

  function automatic int gap_of(input int u);
    return (u == 0) ? 1 : (u == 1) ? 3 : 2;
  endfunction

  function automatic int rst_of(input int u);
    return (u == 2) ? 3 : 1;
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < NU; gi++) begin : g_unit
      lock_code_sender #(
        .GAP_CYCLES   ((gi == 0) ? 1 : (gi == 1) ? 3 : 2),
        .RESET_CYCLES ((gi == 2) ? 3 : 1)
      ) dut (
        .clk        (clk),
        .reset      (rst_s[gi]),
        .start      (start_s[gi]),
        .code       (code_s[gi]),
        .lock_open  (lock_open_s[gi]),
        .lock_reset (lock_reset_s[gi]),
        .numbers    (numbers_s[gi]),
        .try        (try_s[gi]),
        .busy       (busy_s[gi]),
        .done       (done_s[gi]),
        .ok         (ok_s[gi])
      );

      // Behavioural lock: one count per rising edge of try on the selected button.
      logic [15:0] lk_cnt = '0;
      logic        lk_try_q = 1'b0;
      always @(posedge clk) begin
        lk_try_q <= try_s[gi];
        if (lock_reset_s[gi]) begin
          lk_cnt <= '0;
        end else if (try_s[gi] && !lk_try_q) begin
          for (int b = 0; b < 4; b++)
            if (numbers_s[gi][b]) lk_cnt[b*4 +: 4] <= lk_cnt[b*4 +: 4] + 4'd1;
        end
      end
      assign lock_open_s[gi] = (lk_cnt == LOCK_CODE);
    end
  endgenerate

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One sequence on unit u. abort_after>0 resets the block after that many presses;
  // disturb re-pulses start with code 0xFFFF while the sequence is running.
  task automatic run(input int u, input logic [15:0] cv, input int abort_after, input bit disturb);
    int k, presses, last_t, min_gap, viol, s, exp_done, g, r;
    int bc[4];
    bit finished, multi;
    g = gap_of(u);
    r = rst_of(u);
    presses = 0; last_t = -1; min_gap = 100000; viol = 0; finished = 1'b0;
    bc = '{default: 0};
    @(negedge clk);
    code_s[u]  = cv;
    start_s[u] = 1'b1;
    for (k = 1; k <= 1000; k++) begin
      @(negedge clk);
      start_s[u] = (disturb && k == 3);
      if (disturb && k == 3) code_s[u] = 16'hFFFF;
      if (!busy_s[u]) viol++;
      if ((k <= r) != lock_reset_s[u]) viol++;
      if (try_s[u] && lock_reset_s[u]) viol++;
      if ($countones(numbers_s[u]) > 1) viol++;
      if (try_s[u]) begin
        if ($countones(numbers_s[u]) != 1) viol++;
        for (int b = 0; b < 4; b++) if (numbers_s[u][b]) bc[b]++;
        presses++;
        if (last_t >= 0 && k - last_t < min_gap) min_gap = k - last_t;
        last_t = k;
        if (abort_after != 0 && presses == abort_after) begin
          rst_s[u] = 1'b1;
          @(negedge clk);
          rst_s[u] = 1'b0;
          check("abort_outputs", 32'({lock_reset_s[u], numbers_s[u], try_s[u],
                                      busy_s[u], done_s[u], ok_s[u]}), 32'd0);
          check("abort_invariants", viol, 0);
          $display("unit %0d code %04h: reset after %0d presses", u, cv, presses);
          return;
        end
      end
      if (done_s[u]) begin
        finished = 1'b1;
        break;
      end
    end

    s = 0;
    multi = 1'b0;
    for (int b = 0; b < 4; b++) begin
      s += int'(cv[b*4 +: 4]);
      if (cv[b*4 +: 4] >= 4'd2) multi = 1'b1;
    end
    exp_done = r + 4 + s * (1 + g) + 2;
    check("done_seen", 32'(finished), 32'd1);
    check("done_cycle", k, exp_done);
    check("ok_at_done", 32'(ok_s[u]), 32'(cv == LOCK_CODE));
    for (int b = 0; b < 4; b++) check("presses_per_button", bc[b], int'(cv[b*4 +: 4]));
    check("press_total", presses, s);
    if (multi) check("press_spacing", min_gap, 1 + g);
    check("invariants", viol, 0);
    @(negedge clk);
    check("idle_after_done", 32'({busy_s[u], done_s[u]}), 32'd0);
    check("ok_held", 32'(ok_s[u]), 32'(cv == LOCK_CODE));
    $display("unit %0d code %04h: %0d presses, done at cycle %0d, ok=%0b",
             u, cv, presses, k, ok_s[u]);
  endtask

  initial begin
    logic [15:0] cv;
    for (int u = 0; u < NU; u++) begin
      rst_s[u]   = 1'b1;
      start_s[u] = 1'b0;
      code_s[u]  = '0;
    end
    repeat (3) @(negedge clk);
    for (int u = 0; u < NU; u++)
      check("reset_state", 32'({lock_reset_s[u], numbers_s[u], try_s[u],
                                busy_s[u], done_s[u], ok_s[u]}), 32'd0);
    for (int u = 0; u < NU; u++) rst_s[u] = 1'b0;
    @(negedge clk);

    run(0, LOCK_CODE, 0, 1'b0);
    run(0, 16'h0000,  0, 1'b0);
    run(0, 16'h1234,  0, 1'b0);
    run(0, LOCK_CODE, 5, 1'b0);
    run(0, LOCK_CODE, 0, 1'b0);
    run(0, LOCK_CODE, 0, 1'b1);
    run(0, 16'hFFFF,  0, 1'b0);
    run(1, LOCK_CODE, 0, 1'b0);
    run(1, 16'hFFFF,  0, 1'b0);
    run(2, LOCK_CODE, 0, 1'b0);
    run(2, 16'h0000,  0, 1'b0);

    for (int i = 0; i < 15; i++) begin
      cv = ($urandom_range(0, 3) == 0) ? LOCK_CODE : 16'($urandom);
      run(i % NU, cv, 0, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
